// File: rtl/gpio_pio_pkg.sv
// Shared constants for the Avalon-MM GPIO port: register word addresses and
// edge-capture type selectors.
package gpio_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/gpio_pio_sync.sv
// WIDTH-wide two-flop input synchroniser with a history flop and per-bit
// edge detection selected by EDGE_TYPE.
module gpio_pio_sync
  import gpio_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;

  // Synchroniser chain plus one-cycle history of the synchronised value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {WIDTH{1'b0}};
      r_sync2 <= {WIDTH{1'b0}};
      r_prev  <= {WIDTH{1'b0}};
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_sync = r_sync2;

  // Edge qualification; unknown EDGE_TYPE values fall back to rising
  always_comb begin
    o_edge = r_sync2 & ~r_prev;
    case (EDGE_TYPE)
      EDGE_RISE: o_edge = r_sync2 & ~r_prev;
      EDGE_FALL: o_edge = ~r_sync2 & r_prev;
      EDGE_ANY:  o_edge = r_sync2 ^ r_prev;
      default:   o_edge = r_sync2 & ~r_prev;
    endcase
  end

endmodule

// File: rtl/gpio_pio_avmm.sv
// Avalon-MM bidirectional GPIO with set/clear writes, edge capture and a
// maskable level irq. Define GPIO_PIO_IRQ_EN to build IRQMASK and the irq path.
module gpio_pio_avmm
  import gpio_pio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = {WIDTH{1'b0}},
  parameter int               EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_irqmask;
  logic [WIDTH-1:0] w_rd_field;
  logic             w_unused;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_edge_cap;

  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_unused = ^writedata;

  gpio_pio_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_pin   (in_port),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

  // Output data register: plain load, atomic OR-set and AND-NOT-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_OUT;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:   r_data_out <= w_wd;
        ADDR_OUTSET: r_data_out <= r_data_out | w_wd;
        ADDR_OUTCLR: r_data_out <= r_data_out & ~w_wd;
        default:     r_data_out <= r_data_out;
      endcase
    end
  end

  // Direction register, one bit per pin, 1 = drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dir <= {WIDTH{1'b0}};
    end else if (w_wr && (address == ADDR_DIR)) begin
      r_dir <= w_wd;
    end
  end

  // Write-1-to-clear mask for the edge capture register
  always_comb begin
    w_clr = {WIDTH{1'b0}};
    if (w_wr && (address == ADDR_EDGECAP)) begin
      w_clr = w_wd;
    end else begin
      w_clr = {WIDTH{1'b0}};
    end
  end

  // Sticky edge capture; a new edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cap <= {WIDTH{1'b0}};
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
    end
  end

`ifdef GPIO_PIO_IRQ_EN
  logic [WIDTH-1:0] r_irqmask;

  // Interrupt mask, one bit per pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= {WIDTH{1'b0}};
    end else if (w_wr && (address == ADDR_IRQMASK)) begin
      r_irqmask <= w_wd;
    end
  end

  assign w_irqmask = r_irqmask;
  assign irq       = |(r_edge_cap & r_irqmask);
`else
  assign w_irqmask = {WIDTH{1'b0}};
  assign irq       = 1'b0;
`endif

  assign out_port = r_data_out;
  assign oe       = r_dir;

  // Zero-wait-state read mux; DATA always returns the pins, never data_out
  always_comb begin
    w_rd_field = {WIDTH{1'b0}};
    case (address)
      ADDR_DATA:    w_rd_field = w_sync;
      ADDR_DIR:     w_rd_field = r_dir;
      ADDR_IRQMASK: w_rd_field = w_irqmask;
      ADDR_EDGECAP: w_rd_field = r_edge_cap;
      default:      w_rd_field = {WIDTH{1'b0}};
    endcase
    readdata                = 32'd0;
    readdata[WIDTH-1:0]     = w_rd_field;
  end

endmodule
